muldiv_sequencer: RTL and testbench

Sequences the iterative mult and div units and the Hi/Lo register pair for the multicycle CPU. It accepts a one-cycle request from control_unit and times the unit's iterations with a counter. It then drives HiLo_load and the hi/lo select muxes for exactly one cycle, and reports done or a divide-by-zero exception. It also produces a stall for mfhi/mflo issued while an operation is in flight.

---
 rtl/muldiv_sequencer_pkg.sv | 19 +
 rtl/muldiv_sequencer_if.sv | 27 ++
 rtl/muldiv_iter_counter.sv | 25 ++
 rtl/muldiv_sequencer.sv | 74 +++++++
 tb/tb_muldiv_sequencer.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared state encodings and Hi/Lo mux selects for the mult/div sequencer
package muldiv_sequencer_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RUN_MULT = 3'd1;
    localparam logic [2:0] ST_RUN_DIV  = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_EXC      = 3'd5;

    // must match the encodings used by mux_hi_select / mux_lo_select
    localparam logic HILO_SEL_DIV  = 1'b0;
    localparam logic HILO_SEL_MULT = 1'b1;

    function automatic logic is_run(input logic [2:0] s);
        return (s == ST_RUN_MULT) || (s == ST_RUN_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between control_unit and the mult/div sequencer
interface muldiv_sequencer_if;
    logic        req_mult;
    logic        req_div;
    logic [31:0] divisor;
    logic        hilo_read;
    logic        abort;
    logic        mult_start;
    logic        div_start;
    logic        HiLo_load;
    logic        sel_mux_hi;
    logic        sel_mux_lo;
    logic        busy;
    logic        stall;
    logic        done;
    logic        div_zero;

    modport master (
        output req_mult, req_div, divisor, hilo_read, abort,
        input  mult_start, div_start, HiLo_load, sel_mux_hi, sel_mux_lo, busy, stall, done, div_zero
    );

    modport slave (
        input  req_mult, req_div, divisor, hilo_read, abort,
        output mult_start, div_start, HiLo_load, sel_mux_hi, sel_mux_lo, busy, stall, done, div_zero
    );
endinterface

// File: rtl/muldiv_iter_counter.sv
// muldiv_iter_counter: loadable down-counter with zero flag that times unit iterations
module muldiv_iter_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // clear beats load beats decrement; holds at zero instead of wrapping
    always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : (en_i && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

    // counter register
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences mult/div iterations, Hi/Lo load, done and divide-by-zero reporting
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input logic               clk,
    input logic               reset,
    muldiv_sequencer_if.slave bus
);
    logic [2:0]       state_q, state_d;
    logic             op_is_mult_q, mult_start_q, div_start_q, hilo_load_q, sel_q, done_q, div_zero_q;
    logic             cnt_zero, cnt_load;
    logic [CNT_W-1:0] cnt_init;

    // next state: abort wins everywhere, mult wins over div, zero divisor diverts to EXC
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:                 state_d = bus.abort ? ST_IDLE : bus.req_mult ? ST_RUN_MULT : !bus.req_div ? ST_IDLE : (bus.divisor != 32'd0) ? ST_RUN_DIV : ST_EXC;
            ST_RUN_MULT, ST_RUN_DIV: state_d = bus.abort ? ST_IDLE : cnt_zero ? ST_WRITE : state_q;
            ST_WRITE:                state_d = bus.abort ? ST_IDLE : ST_DONE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    assign cnt_load = (state_q == ST_IDLE) && is_run(state_d);
    assign cnt_init = (state_d == ST_RUN_MULT) ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

    muldiv_iter_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (bus.abort),
        .load_i     (cnt_load),
        .en_i       (is_run(state_q)),
        .load_val_i (cnt_init),
        .zero_o     (cnt_zero)
    );

    // state and outputs; outputs are decoded from the next state so they coincide with their state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_is_mult_q <= 1'b0;
            mult_start_q <= 1'b0;
            div_start_q  <= 1'b0;
            hilo_load_q  <= 1'b0;
            sel_q        <= 1'b0;
            done_q       <= 1'b0;
            div_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_is_mult_q <= cnt_load ? (state_d == ST_RUN_MULT) : op_is_mult_q;
            mult_start_q <= cnt_load && (state_d == ST_RUN_MULT);
            div_start_q  <= cnt_load && (state_d == ST_RUN_DIV);
            hilo_load_q  <= (state_d == ST_WRITE);
            sel_q        <= (state_d == ST_WRITE) ? (op_is_mult_q ? HILO_SEL_MULT : HILO_SEL_DIV) : sel_q;
            done_q       <= (state_d == ST_DONE);
            div_zero_q   <= (state_d == ST_EXC);
        end
    end

    assign bus.mult_start = mult_start_q;
    assign bus.div_start  = div_start_q;
    assign bus.HiLo_load  = hilo_load_q;
    assign bus.sel_mux_hi = sel_q;
    assign bus.sel_mux_lo = sel_q;
    assign bus.done       = done_q;
    assign bus.div_zero   = div_zero_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.stall      = bus.hilo_read && (is_run(state_q) || state_q == ST_WRITE);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed checks of sequencing, latency, abort and stall behaviour
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    int n_ms, n_ds, n_ld, n_dn, n_dz, n_st;
    int ms_off, ld_off, dn_off, dz_off, idle_off, st_last, sel_hi_ld, sel_lo_ld;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.MULT_CYCLES(32), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // issue one request, then watch a fixed 40-cycle window; offset k = k cycles after the request edge
    task automatic run_op(input logic m, input logic d, input logic [31:0] dvs, input int abort_off, input int rd_off, input logic rd);
        n_ms = 0; n_ds = 0; n_ld = 0; n_dn = 0; n_dz = 0; n_st = 0;
        ms_off = 0; ld_off = 0; dn_off = 0; dz_off = 0; idle_off = 0; st_last = 0;
        sel_hi_ld = -1; sel_lo_ld = -1;
        bus.req_mult = m; bus.req_div = d; bus.divisor = dvs; bus.hilo_read = rd;
        bus.abort = (abort_off == 0);
        tick;
        bus.req_mult = 1'b0;
        for (int off = 1; off <= 40; off++) begin
            bus.abort = (off == abort_off);
            bus.req_div = (off == rd_off);
            if (bus.mult_start) begin n_ms++; ms_off = off; end
            if (bus.div_start) n_ds++;
            if (bus.HiLo_load) begin
                n_ld++; ld_off = off;
                sel_hi_ld = int'(bus.sel_mux_hi); sel_lo_ld = int'(bus.sel_mux_lo);
            end
            if (bus.done) begin n_dn++; dn_off = off; end
            if (bus.div_zero) begin n_dz++; dz_off = off; end
            if (bus.stall) begin n_st++; st_last = off; end
            if (!bus.busy && idle_off == 0) idle_off = off;
            tick;
        end
        bus.abort = 1'b0; bus.req_div = 1'b0; bus.hilo_read = 1'b0;
    endtask

    initial begin
        bus.req_mult = 1'b0; bus.req_div = 1'b0; bus.divisor = 32'd0;
        bus.hilo_read = 1'b1; bus.abort = 1'b0;
        tick; tick;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("reset_outputs", 32'({bus.mult_start, bus.div_start, bus.HiLo_load, bus.sel_mux_hi, bus.sel_mux_lo,
                                      bus.busy, bus.stall, bus.done, bus.div_zero}), 32'd0);
            tick;
        end
        bus.hilo_read = 1'b0;

        run_op(1'b1, 1'b0, 32'd0, -1, -1, 1'b1);
        chk("mult_start_cnt", n_ms, 1);
        chk("mult_start_off", ms_off, 1);
        chk("mult_div_start", n_ds, 0);
        chk("mult_load_cnt", n_ld, 1);
        chk("mult_load_off", ld_off, 33);
        chk("mult_sel_hi", sel_hi_ld, 1);
        chk("mult_sel_lo", sel_lo_ld, 1);
        chk("mult_done_cnt", n_dn, 1);
        chk("mult_done_off", dn_off, 34);
        chk("mult_idle_off", idle_off, 35);
        chk("mult_stall_cnt", n_st, 33);
        chk("mult_stall_last", st_last, 33);

        run_op(1'b0, 1'b1, 32'h0, -1, -1, 1'b1);
        chk("dz_cnt", n_dz, 1);
        chk("dz_off", dz_off, 1);
        chk("dz_div_start", n_ds, 0);
        chk("dz_load", n_ld, 0);
        chk("dz_done", n_dn, 0);
        chk("dz_stall", n_st, 0);
        chk("dz_idle_off", idle_off, 2);

        run_op(1'b0, 1'b1, 32'h7, -1, -1, 1'b0);
        chk("div_start_cnt", n_ds, 1);
        chk("div_load_off", ld_off, 33);
        chk("div_sel_hi", sel_hi_ld, 0);
        chk("div_sel_lo", sel_lo_ld, 0);
        chk("div_done_off", dn_off, 34);
        chk("div_stall_nord", n_st, 0);
        chk("div_sel_hold", 32'(bus.sel_mux_hi), 32'd0);

        run_op(1'b1, 1'b1, 32'h7, -1, -1, 1'b0);
        chk("both_mult_start", n_ms, 1);
        chk("both_div_start", n_ds, 0);
        chk("both_sel_hi", sel_hi_ld, 1);
        chk("both_load_cnt", n_ld, 1);

        run_op(1'b1, 1'b0, 32'h7, -1, 5, 1'b0);
        chk("busyreq_div_start", n_ds, 0);
        chk("busyreq_load_cnt", n_ld, 1);
        chk("busyreq_idle_off", idle_off, 35);

        run_op(1'b0, 1'b1, 32'h7, 10, -1, 1'b0);
        chk("abort_div_start", n_ds, 1);
        chk("abort_div_load", n_ld, 0);
        chk("abort_div_done", n_dn, 0);
        chk("abort_div_idle", idle_off, 11);

        run_op(1'b1, 1'b0, 32'h7, 32, -1, 1'b0);
        chk("abort_prewr_load", n_ld, 0);
        chk("abort_prewr_done", n_dn, 0);
        chk("abort_prewr_idle", idle_off, 33);

        run_op(1'b1, 1'b0, 32'h7, 33, -1, 1'b0);
        chk("abort_wr_load", n_ld, 1);
        chk("abort_wr_done", n_dn, 0);
        chk("abort_wr_idle", idle_off, 34);

        run_op(1'b1, 1'b0, 32'h7, 0, -1, 1'b0);
        chk("abort_req_start", n_ms, 0);
        chk("abort_req_idle", idle_off, 1);

        run_op(1'b1, 1'b0, 32'h0, -1, -1, 1'b0);
        chk("post_load_off", ld_off, 33);
        chk("post_done_off", dn_off, 34);
        chk("post_sel_hi", sel_hi_ld, 1);
        chk("post_idle_off", idle_off, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
